// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests
// over req/gnt/rvalid and drives the IF/ID register with stall, skid and redirect handling.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        misalign_o
);

    typedef enum logic [2:0] {BOOT, FETCH, WAIT, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        skid_vld_q;
    logic [31:0] skid_pc_q, skid_instr_q;
    logic [31:0] if_id_pc_q, if_id_instr_q;
    logic        if_id_valid_q;
    logic        misalign_q;

    logic        deliver, capture;
    logic [31:0] deliver_pc, deliver_instr;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

    // Next state plus the one-cycle deliver/capture strobes; redirect always wins.
    always_comb begin
        state_d       = state_q;
        deliver       = 1'b0;
        capture       = 1'b0;
        deliver_pc    = pc_q;
        deliver_instr = imem_rdata_i;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (redirect_i) begin
                    state_d = imem_gnt_i ? DROP : FETCH;
                end else if (imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    state_d = imem_rvalid_i ? FETCH : DROP;
                end else if (imem_rvalid_i) begin
                    if (stall_i) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    state_d = FETCH;
                end else if (!stall_i && skid_vld_q) begin
                    deliver       = 1'b1;
                    deliver_pc    = skid_pc_q;
                    deliver_instr = skid_instr_q;
                    state_d       = FETCH;
                end
            end
            DROP: begin
                // The cancelled response is swallowed here whatever pc_q now holds.
                if (imem_rvalid_i) begin
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_tgt;
        end else if (deliver) begin
            pc_d = deliver_pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_vld_q   <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= NOP_INSTR;
        end else if (redirect_i || deliver) begin
            skid_vld_q <= 1'b0;
        end else if (capture) begin
            skid_vld_q   <= 1'b1;
            skid_pc_q    <= pc_q;
            skid_instr_q <= imem_rdata_i;
        end
    end

    // IF/ID: flush beats stall, stall beats delivery, otherwise a bubble keeps the pc fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= 32'd0;
        end else if (redirect_i) begin
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= NOP_INSTR;
        end else if (!stall_i) begin
            if (deliver) begin
                if_id_valid_q <= 1'b1;
                if_id_instr_q <= deliver_instr;
                if_id_pc_q    <= deliver_pc;
            end else begin
                if_id_valid_q <= 1'b0;
                if_id_instr_q <= NOP_INSTR;
            end
        end
    end

    assign imem_req_o       = (state_q == FETCH);
    assign imem_addr_o      = pc_q;
    assign pc_o             = pc_q;
    assign if_id_pc_o       = if_id_pc_q;
    assign if_id_pc_plus4_o = if_id_pc_q + 32'd4;
    assign if_id_instr_o    = if_id_instr_q;
    assign if_id_valid_o    = if_id_valid_q;
    assign misalign_o       = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: scripted imem responses, expected IF/ID contents
// queued when a response is driven and matched when the stage delivers it.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        misalign;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_v = 1'b0;
    logic [31:0] prev_pc = 32'd0;

    if_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .imem_req_o       (req),
        .imem_addr_o      (addr),
        .imem_gnt_i       (gnt),
        .imem_rvalid_i    (rvalid),
        .imem_rdata_i     (rdata),
        .pc_o             (pc),
        .if_id_pc_o       (if_id_pc),
        .if_id_pc_plus4_o (if_id_pc_plus4),
        .if_id_instr_o    (if_id_instr),
        .if_id_valid_o    (if_id_valid),
        .misalign_o       (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then match any newly delivered IF/ID entry against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (if_id_valid === 1'b1 && (!prev_v || if_id_pc !== prev_pc)) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed delivery pc %h expected none", if_id_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_pc", if_id_pc, e.pc);
                chk("sb_instr", if_id_instr, e.instr);
                chk("sb_pc_plus4", if_id_pc_plus4, e.pc + 32'd4);
            end
        end
        prev_v  = if_id_valid;
        prev_pc = if_id_pc;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] w);
        chk("req_in_fetch", {31'd0, req}, 32'd1);
        chk("fetch_addr", addr, a);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("req_in_wait", {31'd0, req}, 32'd0);
        rvalid = 1'b1;
        rdata  = w;
        sb.push_back('{pc: a, instr: w});
        step();
        rvalid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        gnt         = 1'b0;
        rvalid      = 1'b0;
        rdata       = 32'd0;
        repeat (2) @(posedge clk);
        #1;

        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_if_id_pc", if_id_pc, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);

        rst_n = 1'b1;
        chk("boot_req", {31'd0, req}, 32'd0);
        step();

        // Straight-line fetch, then a 3-cycle stall starting on the 0x4 response.
        fetch(32'h0, 32'hA000_0000);
        chk("next_addr_4", addr, 32'h4);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("bubble_valid", {31'd0, if_id_valid}, 32'd0);
        chk("bubble_instr", if_id_instr, NOP);
        rvalid = 1'b1;
        rdata  = 32'hA000_0004;
        stall  = 1'b1;
        sb.push_back('{pc: 32'h4, instr: 32'hA000_0004});
        step();
        rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("hold_req", {31'd0, req}, 32'd0);
            chk("hold_if_id_pc", if_id_pc, 32'h0);
            chk("hold_valid", {31'd0, if_id_valid}, 32'd0);
            step();
        end
        stall = 1'b0;
        step();
        chk("after_hold_addr", addr, 32'h8);
        fetch(32'h8, 32'hA000_0008);

        // Redirect while waiting: response is dropped, next request at the target.
        chk("addr_c", addr, 32'hC);
        gnt = 1'b1;
        step();
        gnt         = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        chk("drop_req", {31'd0, req}, 32'd0);
        chk("drop_valid", {31'd0, if_id_valid}, 32'd0);
        chk("drop_instr", if_id_instr, NOP);
        step();
        chk("drop_wait_req", {31'd0, req}, 32'd0);
        rvalid = 1'b1;
        rdata  = 32'hBAD0_000C;
        step();
        rvalid = 1'b0;
        chk("post_drop_req", {31'd0, req}, 32'd1);
        chk("post_drop_addr", addr, 32'h100);

        // Redirect, response and stall together in WAIT.
        gnt = 1'b1;
        step();
        gnt         = 1'b0;
        rvalid      = 1'b1;
        rdata       = 32'hBAD0_0100;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        stall       = 1'b1;
        step();
        rvalid   = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        chk("rr_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rr_instr", if_id_instr, NOP);
        chk("rr_pc", pc, 32'h200);
        chk("rr_req", {31'd0, req}, 32'd1);
        chk("rr_misalign", {31'd0, misalign}, 32'd0);

        // Flush of a held valid entry plus a misaligned target.
        fetch(32'h200, 32'hA000_0200);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h206;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        chk("flush_valid", {31'd0, if_id_valid}, 32'd0);
        chk("flush_instr", if_id_instr, NOP);
        chk("misalign_pulse", {31'd0, misalign}, 32'd1);
        chk("misalign_addr", addr, 32'h204);
        chk("misalign_req", {31'd0, req}, 32'd1);
        step();
        chk("misalign_clear", {31'd0, misalign}, 32'd0);
        fetch(32'h204, 32'hA000_0204);

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        fetch(32'hFFFF_FFFC, 32'hA000_FFFC);
        chk("wrap_plus4", if_id_pc_plus4, 32'h0);
        chk("wrap_addr", addr, 32'h0);

        // Asynchronous reset while a request is outstanding.
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, req}, 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("arst_instr", if_id_instr, NOP);
        chk("arst_if_id_pc", if_id_pc, 32'd0);
        step();
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hBAD0_0000;
        step();
        rvalid = 1'b0;
        chk("stale_valid", {31'd0, if_id_valid}, 32'd0);
        chk("stale_req", {31'd0, req}, 32'd1);
        chk("stale_addr", addr, 32'h0);
        step();
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
